i_ram_program_loader: RTL and testbench

- Sequences and arbitrates the single write port of the instruction RAM.
- Boot/reload path: accepts a byte stream (header plus 32-bit words) over a valid/ready handshake, assembles words, and writes them to consecutive RAM addresses.
- Stalls the processor while a load is in progress.
- Outside a load, grants the write port to the processor's own write requests.

---
 rtl/i_ram_program_loader_pkg.sv | 19 +
 rtl/i_ram_program_loader_byte_word_assembler.sv | 37 +++
 rtl/i_ram_program_loader.sv | 154 +++++++++++++++
 tb/tb_i_ram_program_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_ram_program_loader_pkg.sv
// Shared constants for the instruction-RAM program loader and the RAM it feeds.
package i_ram_program_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HEADER_BYTES   = 4;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

  // Instruction RAM depth; also used by the RAM itself.
  localparam int unsigned I_RAM_DEPTH    = 872;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_HDR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/i_ram_program_loader_byte_word_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; the header reuses it as one word.
module i_ram_program_loader_byte_word_assembler
  import i_ram_program_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_fire,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [CNT_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] shift_q;

  // The completing byte is merged combinationally so the word is usable on its own edge.
  assign word_valid_c = byte_fire && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_c       = {shift_q, byte_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_fire) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      shift_q <= {shift_q[SHIFT_W-BYTE_W-1:0], byte_in};
    end
  end

endmodule

// File: rtl/i_ram_program_loader.sv
// Owns the instruction-RAM write port: streams a header-framed program into the RAM,
// stalling the CPU meanwhile, and otherwise forwards CPU write requests.
module i_ram_program_loader
  import i_ram_program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = I_RAM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  cpu_write_request,
  input  logic [ADDR_WIDTH-1:0] cpu_write_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_write_grant,
  output logic                  cpu_stall,
  output logic                  flag_write_i_ram,
  output logic [ADDR_WIDTH-1:0] i_ram_writing_address,
  output logic [DATA_WIDTH-1:0] i_ram_input,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  localparam int unsigned FIELD_W = 16;
  localparam int unsigned SUM_W   = FIELD_W + 1;

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [FIELD_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] words_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  wr_d, err_d, done_d, stall_d, ready_d;

  logic                  byte_fire_c, asm_clear_c, word_valid_c;
  logic [WORD_W-1:0]     word_c;
  logic [FIELD_W-1:0]    hdr_start, hdr_count;
  logic [SUM_W-1:0]      hdr_end;
  logic                  hdr_bad;
  logic                  cpu_side;

  assign byte_fire_c = byte_valid && byte_ready;

  i_ram_program_loader_byte_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear        (asm_clear_c),
    .byte_fire    (byte_fire_c),
    .byte_in      (byte_in),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Header: start address in the upper half, word count in the lower half; sum kept unwrapped.
  assign hdr_start = word_c[WORD_W-1 -: FIELD_W];
  assign hdr_count = word_c[FIELD_W-1:0];
  assign hdr_end   = SUM_W'(hdr_start) + SUM_W'(hdr_count);
  assign hdr_bad   = (hdr_count == '0) || ((hdr_start >> ADDR_WIDTH) != '0) ||
                     (hdr_end > SUM_W'(RAM_DEPTH));

  assign cpu_side        = (state_q == ST_IDLE) || (state_q == ST_ERR);
  assign cpu_write_grant = cpu_write_request && !load_start && cpu_side;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    words_d     = words_loaded;
    addr_d      = i_ram_writing_address;
    data_d      = i_ram_input;
    wr_d        = 1'b0;
    err_d       = load_error;
    asm_clear_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (load_start) begin
          state_d     = ST_HDR;
          words_d     = '0;
          err_d       = 1'b0;
          asm_clear_c = 1'b1;
        end else if (cpu_write_request) begin
          wr_d   = 1'b1;
          addr_d = cpu_write_address;
          data_d = cpu_write_data;
        end
      end
      ST_HDR: begin
        if (word_valid_c) begin
          if (hdr_bad) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_DATA;
            ptr_d       = ADDR_WIDTH'(hdr_start);
            remaining_d = hdr_count;
          end
        end
      end
      ST_DATA: begin
        if (word_valid_c) begin
          wr_d        = 1'b1;
          addr_d      = ptr_q;
          data_d      = DATA_WIDTH'(word_c);
          words_d     = words_loaded + ADDR_WIDTH'(1);
          remaining_d = remaining_q - FIELD_W'(1);
          // The pointer stops on the last word so it never leaves the RAM.
          if (remaining_q == FIELD_W'(1)) state_d = ST_DONE;
          else                            ptr_d   = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
    stall_d = ready_d || (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q               <= ST_IDLE;
      ptr_q                 <= '0;
      remaining_q           <= '0;
      words_loaded          <= '0;
      flag_write_i_ram      <= 1'b0;
      i_ram_writing_address <= '0;
      i_ram_input           <= '0;
      load_error            <= 1'b0;
      load_done             <= 1'b0;
      cpu_stall             <= 1'b0;
      byte_ready            <= 1'b0;
    end else begin
      state_q               <= state_d;
      ptr_q                 <= ptr_d;
      remaining_q           <= remaining_d;
      words_loaded          <= words_d;
      flag_write_i_ram      <= wr_d;
      i_ram_writing_address <= addr_d;
      i_ram_input           <= data_d;
      load_error            <= err_d;
      load_done             <= done_d;
      cpu_stall             <= stall_d;
      byte_ready            <= ready_d;
    end
  end

endmodule

// File: tb/tb_i_ram_program_loader.sv
// Randomized bench for the program loader against a header/stream reference model.
module tb_i_ram_program_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 872;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          cpu_write_request = 1'b0;
  logic [AW-1:0] cpu_write_address = '0;
  logic [DW-1:0] cpu_write_data = '0;
  logic          cpu_write_grant, cpu_stall, flag_write_i_ram, load_done, load_error;
  logic [AW-1:0] i_ram_writing_address, words_loaded;
  logic [DW-1:0] i_ram_input;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  logic [7:0]       stream[$];
  logic [AW+DW-1:0] exp_log[$];
  logic [AW+DW-1:0] wlog[$];

  i_ram_program_loader dut (
    .clock                 (clock),
    .reset                 (reset),
    .load_start            (load_start),
    .byte_in               (byte_in),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .cpu_write_request     (cpu_write_request),
    .cpu_write_address     (cpu_write_address),
    .cpu_write_data        (cpu_write_data),
    .cpu_write_grant       (cpu_write_grant),
    .cpu_stall             (cpu_stall),
    .flag_write_i_ram      (flag_write_i_ram),
    .i_ram_writing_address (i_ram_writing_address),
    .i_ram_input           (i_ram_input),
    .load_done             (load_done),
    .load_error            (load_error),
    .words_loaded          (words_loaded)
  );

  always #5 clock = ~clock;

  // Record every RAM write and every done pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (flag_write_i_ram === 1'b1) wlog.push_back({i_ram_writing_address, i_ram_input});
    if (load_done === 1'b1) done_cnt++;
  end

  // Reference: decode header, reject bad ones, else list (address, big-endian word) pairs.
  function automatic bit model_load();
    int start, count;
    exp_log.delete();
    start = int'({stream[0], stream[1]});
    count = int'({stream[2], stream[3]});
    if (count == 0 || start >= (1 << AW) || start + count > DEPTH) return 1'b1;
    for (int w = 0; w < count; w++)
      exp_log.push_back({AW'(start + w), stream[4+4*w], stream[5+4*w], stream[6+4*w], stream[7+4*w]});
    return 1'b0;
  endfunction

  task automatic make_stream(input int start, input int count, input int words);
    stream.delete();
    stream.push_back(8'(start >> 8));
    stream.push_back(8'(start));
    stream.push_back(8'(count >> 8));
    stream.push_back(8'(count));
    for (int k = 0; k < words * 4; k++) stream.push_back(8'($urandom));
  endtask

  // Runs one load of the current stream and checks the whole visible outcome.
  task automatic do_load(input string tag, input int pct, input int mid_start, input bit hold);
    bit               exp_err;
    int               acc, sl, gr, cyc;
    bit               fire;
    logic [AW+DW-1:0] exp_all[$];
    logic [AW+DW-1:0] got;
    exp_err = model_load();
    exp_all = exp_log;
    if (hold) exp_all.push_back({cpu_write_address, cpu_write_data});
    wlog.delete();
    done_cnt = 0;
    load_start = 1'b1;
    #1;
    tests_run++;
    if (cpu_write_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s start_priority: grant=%b required 0", tag, cpu_write_grant);
    end
    @(posedge clock); #1;
    load_start = 1'b0;
    acc = 0; sl = 0; gr = 0; cyc = 0;
    while (acc < stream.size() && cyc < 20000) begin
      byte_in    = stream[acc];
      byte_valid = ($urandom_range(99) < 32'(pct));
      load_start = (acc == mid_start);
      #1;
      fire = byte_valid && byte_ready;
      if (cpu_stall !== 1'b1) sl++;
      if (cpu_write_grant !== 1'b0) gr++;
      @(posedge clock); #1;
      if (fire) acc++;
      cyc++;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    tests_run++;
    if (acc != stream.size()) begin
      tests_failed++;
      $display("FAIL %s bytes_accepted: got %0d required %0d", tag, acc, stream.size());
    end
    tests_run++;
    if (sl != 0 || gr != 0) begin
      tests_failed++;
      $display("FAIL %s stall_during_load: stall_low=%0d grants=%0d required 0 0", tag, sl, gr);
    end
    tests_run++;
    if (cpu_write_grant !== (exp_err ? cpu_write_request : 1'b0)) begin
      tests_failed++;
      $display("FAIL %s grant_after_stream: got %b required %b", tag, cpu_write_grant,
               exp_err ? cpu_write_request : 1'b0);
    end
    @(posedge clock); #1;
    tests_run++;
    if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || cpu_write_grant !== cpu_write_request) begin
      tests_failed++;
      $display("FAIL %s idle_after: stall=%b ready=%b grant=%b required 0 0 %b", tag,
               cpu_stall, byte_ready, cpu_write_grant, cpu_write_request);
    end
    @(posedge clock); #1;
    cpu_write_request = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (wlog.size() != exp_all.size()) begin
      tests_failed++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wlog.size(), exp_all.size());
    end
    for (int k = 0; k < exp_all.size(); k++) begin
      got = (k < wlog.size()) ? wlog[k] : 'x;
      tests_run++;
      if (got !== exp_all[k]) begin
        tests_failed++;
        $display("FAIL %s write_%0d: got addr=%0d data=%h required addr=%0d data=%h", tag, k,
                 got[AW+DW-1:DW], got[DW-1:0], exp_all[k][AW+DW-1:DW], exp_all[k][DW-1:0]);
      end
    end
    tests_run++;
    if (done_cnt != (exp_err ? 0 : 1) || load_error !== exp_err) begin
      tests_failed++;
      $display("FAIL %s done_error: done_pulses=%0d error=%b required %0d %b", tag, done_cnt,
               load_error, exp_err ? 0 : 1, exp_err);
    end
    tests_run++;
    if (words_loaded !== AW'(exp_log.size())) begin
      tests_failed++;
      $display("FAIL %s words_loaded: got %0d required %0d", tag, words_loaded, exp_log.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({flag_write_i_ram, i_ram_writing_address, i_ram_input, words_loaded, load_error,
         load_done, cpu_stall, byte_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: flag=%b addr=%0d data=%h words=%0d err=%b done=%b stall=%b ready=%b required all 0",
               flag_write_i_ram, i_ram_writing_address, i_ram_input, words_loaded, load_error,
               load_done, cpu_stall, byte_ready);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if ({flag_write_i_ram, load_error, load_done, cpu_stall, byte_ready, cpu_write_grant} !== '0) begin
      tests_failed++;
      $display("FAIL idle_outputs: flag=%b err=%b done=%b stall=%b ready=%b grant=%b required all 0",
               flag_write_i_ram, load_error, load_done, cpu_stall, byte_ready, cpu_write_grant);
    end
  endtask

  task automatic test_cpu_write();
    for (int k = 0; k < 9; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = (k == 0) ? AW'(5) : AW'($urandom_range(DEPTH - 1));
      d = (k == 0) ? 32'hDEADBEEF : DW'($urandom);
      cpu_write_request = 1'b1;
      cpu_write_address = a;
      cpu_write_data    = d;
      #1;
      tests_run++;
      if (cpu_write_grant !== 1'b1) begin
        tests_failed++;
        $display("FAIL cpu_grant_%0d: got %b required 1", k, cpu_write_grant);
      end
      @(posedge clock); #1;
      cpu_write_request = 1'b0;
      tests_run++;
      if (flag_write_i_ram !== 1'b1 || i_ram_writing_address !== a || i_ram_input !== d) begin
        tests_failed++;
        $display("FAIL cpu_write_%0d: got flag=%b addr=%0d data=%h required 1 %0d %h", k,
                 flag_write_i_ram, i_ram_writing_address, i_ram_input, a, d);
      end
      @(posedge clock); #1;
      tests_run++;
      if (flag_write_i_ram !== 1'b0) begin
        tests_failed++;
        $display("FAIL cpu_write_drop_%0d: got flag=%b required 0", k, flag_write_i_ram);
      end
    end
  endtask

  task automatic test_three_word();
    stream = {8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    do_load("three_word", 100, -1, 1'b0);
  endtask

  task automatic test_header_errors();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    make_stream(864, 16, 0);
    do_load("hdr_overflow", 100, -1, 1'b0);
    // Error state keeps the flag and hands the port back to the CPU.
    a = AW'($urandom_range(DEPTH - 1));
    d = DW'($urandom);
    cpu_write_request = 1'b1;
    cpu_write_address = a;
    cpu_write_data    = d;
    #1;
    tests_run++;
    if (cpu_write_grant !== 1'b1 || load_error !== 1'b1 || byte_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cpu_grant: grant=%b err=%b ready=%b required 1 1 0", cpu_write_grant,
               load_error, byte_ready);
    end
    @(posedge clock); #1;
    cpu_write_request = 1'b0;
    tests_run++;
    if (flag_write_i_ram !== 1'b1 || i_ram_writing_address !== a || i_ram_input !== d) begin
      tests_failed++;
      $display("FAIL err_cpu_write: got flag=%b addr=%0d data=%h required 1 %0d %h",
               flag_write_i_ram, i_ram_writing_address, i_ram_input, a, d);
    end
    @(posedge clock); #1;
    make_stream($urandom_range(DEPTH - 1), 0, 0);
    do_load("hdr_count_zero", 100, -1, 1'b0);
    make_stream(1024 + $urandom_range(20000), 1, 0);
    do_load("hdr_upper_bits", 100, -1, 1'b0);
    make_stream(870, 3, 0);
    do_load("hdr_one_over", 60, -1, 1'b0);
    make_stream(869, 3, 3);
    do_load("hdr_exact_fit", 100, -1, 1'b0);
    make_stream(0, DEPTH, DEPTH);
    do_load("full_ram", 100, -1, 1'b0);
  endtask

  task automatic test_throttled();
    for (int k = 0; k < 3; k++) begin
      make_stream($urandom_range(DEPTH - 2), 2, 2);
      do_load($sformatf("throttled_%0d", k), 40, -1, 1'b0);
    end
  endtask

  task automatic test_cpu_during_load();
    make_stream($urandom_range(DEPTH - 3), 3, 3);
    cpu_write_request = 1'b1;
    cpu_write_address = AW'($urandom_range(DEPTH - 1));
    cpu_write_data    = DW'($urandom);
    do_load("cpu_during_load", 80, 6, 1'b1);
  endtask

  task automatic test_reset_midload();
    make_stream($urandom_range(DEPTH - 2), 2, 2);
    void'(model_load());
    wlog.delete();
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      byte_in    = stream[k];
      byte_valid = 1'b1;
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({flag_write_i_ram, i_ram_writing_address, i_ram_input, words_loaded, load_error,
         load_done, cpu_stall, byte_ready} !== '0) begin
      tests_failed++;
      $display("FAIL midload_reset_outputs: flag=%b addr=%0d words=%0d stall=%b ready=%b required all 0",
               flag_write_i_ram, i_ram_writing_address, words_loaded, cpu_stall, byte_ready);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (wlog.size() != 1 || wlog[0] !== exp_log[0]) begin
      tests_failed++;
      $display("FAIL midload_writes: got %0d writes first=%h required 1 write %h", wlog.size(),
               (wlog.size() > 0) ? wlog[0] : 'x, exp_log[0]);
    end
    tests_run++;
    if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || flag_write_i_ram !== 1'b0) begin
      tests_failed++;
      $display("FAIL midload_idle: stall=%b ready=%b flag=%b required 0 0 0", cpu_stall,
               byte_ready, flag_write_i_ram);
    end
    make_stream($urandom_range(DEPTH - 4), 4, 4);
    do_load("post_reset_load", 100, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    make_stream($urandom_range(DEPTH - 5), 5, 5);
    do_load("b2b_first", 100, -1, 1'b0);
    make_stream($urandom_range(DEPTH - 2), 2, 2);
    do_load("b2b_second", 70, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_three_word();
    test_header_errors();
    test_throttled();
    test_cpu_during_load();
    test_reset_midload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
